ps2_scan: RTL and testbench
===========================

// Module: ps2_scan
// PURPOSE
//  PS/2 keyboard receiver and scan-code tracker on the fast system clock.
//  Deserialises keyboard frames and decodes E0 (extended) and F0 (break) prefixes.
//  Drives crt_data with the code of the key currently held; it returns to 0 on release.
//  ps2_input samples crt_data on its slow clock to derive key press edges.
// PARAMETERS
//  TIMEOUT_CYCLES  20000  idle clk cycles inside a frame before the frame is aborted
// PORTS
//  clk       in   1  system (fast) clock; all logic on posedge
//  rst       in   1  synchronous, active-high reset
//  ps2_clk   in   1  PS/2 clock pin, asynchronous, open-collector
//  ps2_data  in   1  PS/2 data pin, asynchronous
//  crt_data  out  9  {ext, code[7:0]} of the held key; 9'h000 = no key
// BEHAVIOUR
//  - Reset: crt_data=0; ext/break flags=0; bit counter=0; pause-skip counter=0; synchronisers=1.
//  - Input path: each of ps2_clk and ps2_data passes through a 2-FF synchroniser.
//    A falling edge is synchronised-clock 1 followed by 0 on the next cycle.
//  - Frame format: 11 bits, sampled on each falling edge.
//    Order: start(0), d0..d7 LSB first, odd parity, stop(1).
//  - A start bit read as 1 is ignored; the counter stays at 0.
//  - Timeout: if the counter is nonzero and TIMEOUT_CYCLES pass with no falling edge,
//    the counter returns to 0 and the partial frame is dropped.
//  - Byte complete: set on the 11th edge; processed on the next cycle.
//    crt_data updates no later than 4 clk cycles after the 11th pin falling edge.
//  - Byte decoding:
//    - E0: set the ext flag.
//    - F0: set the break flag.
//    - E1: load a skip count of 7. The following 7 bytes (the rest of the Pause sequence)
//      are dropped; flags are cleared.
//    - AA, FA, EE, FE, FC, 00, FF: ignored; flags cleared; crt_data unchanged.
//    - Other byte, break=0: crt_data <= {ext, byte}.
//      A make of a different key replaces the held code.
//      Typematic repeat rewrites the same value.
//    - Other byte, break=1: if {ext, byte}==crt_data then crt_data <= 0, else unchanged.
//    - Ext and break are cleared after any non-prefix byte.
//  - Examples:
//    - E0 75 -> 9'h175.
//    - E0 F0 75 -> 0.
//    - 29 -> 9'h029; then F0 14 -> stays 9'h029.
//  - Reset asserted mid-frame discards the frame and all flags.
//    The next frame is received normally.
// CONFIGURATION
//  PS2_PARITY_CHECK_EN defined:
//    - A frame with odd-parity mismatch or stop bit = 0 is discarded.
//    - On discard, the ext and break flags are cleared.
//  PS2_PARITY_CHECK_EN undefined:
//    - Parity and stop bits are not checked.
//    - Every 11-bit frame yields a byte.
// STRUCTURE
//  Package ps2_pkg holds the byte constants:
//    PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1.
//    The ignore-list codes: AA, FA, EE, FE, FC, 00, FF.
//  Sub-module ps2_rx_frame contains:
//    - synchronisers, edge detect, shift register, bit counter, timeout counter;
//    - optional parity check;
//    - outputs byte[7:0] and a 1-cycle byte_valid.
//  ps2_scan top: prefix/skip state plus the crt_data register.
// TESTING
//  Bit-bang at ~10 kHz PS/2 clock; allow 4 clk cycles of settle before checks.
//  - Send 29, then F0 29 -> crt_data 9'h029, then 9'h000.
//  - Send E0 75, then E0 F0 75 -> 9'h175, then 9'h000.
//  - Send E0 72; send 6B; send F0 72 -> 9'h172, 9'h06B, still 9'h06B.
//  - Send 5 start+data bits and idle past TIMEOUT_CYCLES, then send 14 -> 9'h014 only.
//    No spurious value appears in between.
//  - With PS2_PARITY_CHECK_EN, send 74 with bad parity -> crt_data unchanged.
//    Resend correctly -> 9'h074.
//  - Send E1 14 77 E1 F0 14 F0 77 -> crt_data stays 0.
//    Pulse rst mid-frame -> 0; next frame received normally.

Source files
------------

// File: rtl/ps2_scan_pkg.sv
// Shared constants for the PS/2 scan-code receiver: prefix bytes and the
// keyboard status codes that never describe a key.
package ps2_pkg;

   localparam logic [7:0] PS2_EXT   = 8'hE0;
   localparam logic [7:0] PS2_BRK   = 8'hF0;
   localparam logic [7:0] PS2_PAUSE = 8'hE1;

   // Bytes following E1 that belong to the Pause sequence.
   localparam logic [2:0] PAUSE_SKIP = 3'd7;

   // Self-test, ack, echo, resend, error and overrun codes.
   function automatic logic is_ignored(input logic [7:0] code);
      case (code)
         8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF: return 1'b1;
         default:                                         return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ps2_scan_if.sv
// PS/2 pin pair plus the held-key code seen by the slow-clock consumer.
interface ps2_scan_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic [8:0] crt_data;

   modport master (output ps2_clk, ps2_data, input crt_data);
   modport slave  (input ps2_clk, ps2_data, output crt_data);
endinterface

// File: rtl/ps2_scan_rx_frame.sv
// PS/2 frame deserialiser: synchronisers, falling-edge detect, 11-bit framing
// and inactivity timeout. Optional parity/stop check under PS2_PARITY_CHECK_EN.
module ps2_rx_frame
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 20000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       frame_bad
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic          clk_meta, clk_sync, clk_prev;
   logic          data_meta, data_sync;
   logic [3:0]    bit_cnt;
   logic [7:0]    shift;
   logic [TW-1:0] timer;
   logic          frame_done;
   logic          fall;

   assign fall = clk_prev & ~clk_sync;

   // NOTE: synchronisers reset to 1 (the idle level of both pins) so that
   // leaving reset never fabricates a falling edge; all state uses <= so every
   // flop samples the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_meta  <= 1'b1;
         clk_sync  <= 1'b1;
         clk_prev  <= 1'b1;
         data_meta <= 1'b1;
         data_sync <= 1'b1;
      end else begin
         clk_meta  <= ps2_clk;
         clk_sync  <= clk_meta;
         clk_prev  <= clk_sync;
         data_meta <= ps2_data;
         data_sync <= data_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt    <= '0;
         shift      <= '0;
         timer      <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (fall) begin
            timer <= '0;
            if (bit_cnt == 4'd0) begin
               if (!data_sync) bit_cnt <= 4'd1;
            end else begin
               if (bit_cnt <= 4'd8) shift <= {data_sync, shift[7:1]};
               if (bit_cnt == 4'd10) begin
                  bit_cnt    <= '0;
                  frame_done <= 1'b1;
               end else begin
                  bit_cnt <= bit_cnt + 4'd1;
               end
            end
         end else if (bit_cnt != 4'd0) begin
            // A stalled frame is dropped so the next start bit aligns cleanly.
            if (timer == TIMEOUT_LAST) begin
               bit_cnt <= '0;
               timer   <= '0;
            end else begin
               timer <= timer + 1'b1;
            end
         end else begin
            timer <= '0;
         end
      end
   end

   assign rx_byte = shift;

`ifdef PS2_PARITY_CHECK_EN
   logic par_bit, stop_bit, frame_ok;

   always_ff @(posedge clk) begin
      if (rst) begin
         par_bit  <= 1'b0;
         stop_bit <= 1'b0;
      end else if (fall) begin
         if (bit_cnt == 4'd9)  par_bit  <= data_sync;
         if (bit_cnt == 4'd10) stop_bit <= data_sync;
      end
   end

   assign frame_ok   = (^{par_bit, shift}) & stop_bit;
   assign byte_valid = frame_done & frame_ok;
   assign frame_bad  = frame_done & ~frame_ok;
`else
   assign byte_valid = frame_done;
   assign frame_bad  = 1'b0;
`endif

endmodule

// File: rtl/ps2_scan.sv
// PS/2 scan-code tracker: E0/F0 prefix decode, Pause-sequence skip and the
// held-key register. Build with PS2_PARITY_CHECK_EN to drop corrupt frames.
module ps2_scan
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 20000
) (
   input  logic        clk,
   input  logic        rst,
   ps2_scan_if.slave   bus
);

   logic [7:0] rx_byte;
   logic       byte_valid;
   logic       frame_bad;
   logic       ext_flag, brk_flag;
   logic [2:0] skip_cnt;
   logic [8:0] held;

   ps2_rx_frame #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk    (bus.ps2_clk),
      .ps2_data   (bus.ps2_data),
      .rx_byte    (rx_byte),
      .byte_valid (byte_valid),
      .frame_bad  (frame_bad)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         held     <= '0;
         ext_flag <= 1'b0;
         brk_flag <= 1'b0;
         skip_cnt <= '0;
      end else if (frame_bad) begin
         ext_flag <= 1'b0;
         brk_flag <= 1'b0;
      end else if (byte_valid) begin
         if (skip_cnt != 3'd0) begin
            skip_cnt <= skip_cnt - 3'd1;
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
         end else if (rx_byte == PS2_EXT) begin
            ext_flag <= 1'b1;
         end else if (rx_byte == PS2_BRK) begin
            brk_flag <= 1'b1;
         end else begin
            // Any non-prefix byte closes the current prefix sequence.
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
            if (rx_byte == PS2_PAUSE) begin
               skip_cnt <= PAUSE_SKIP;
            end else if (!is_ignored(rx_byte)) begin
               if (!brk_flag)                        held <= {ext_flag, rx_byte};
               else if ({ext_flag, rx_byte} == held) held <= '0;
            end
         end
      end
   end

   assign bus.crt_data = held;

endmodule

// File: tb/tb_ps2_scan.sv
// Directed bench for ps2_scan: bit-bangs PS/2 frames and checks the held code.
`timescale 1ns/1ps
module tb_ps2_scan;
   localparam int HALF    = 20;   // clk cycles per PS/2 clock half-period
   localparam int TIMEOUT = 500;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   ps2_scan_if bus ();

   ps2_scan #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic ps2_bit(input logic b);
      bus.ps2_data = b;
      repeat (HALF) @(posedge clk);
      bus.ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      bus.ps2_clk = 1'b1;
   endtask

   task automatic send_bits(input logic [7:0] b, input int nbits, input logic bad_par);
      logic [10:0] f;
      f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
      bus.ps2_data = 1'b1;
      repeat (HALF) @(posedge clk);
   endtask

   task automatic send_chk(input logic [7:0] b, input logic [8:0] exp, input string tag);
      send_bits(b, 11, 1'b0);
      @(negedge clk);
      check(tag, bus.crt_data, exp);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.ps2_clk  = 1'b1;
      bus.ps2_data = 1'b1;
      repeat (5) @(posedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset", bus.crt_data, 9'h000);

      send_chk(8'h29, 9'h029, "make_29");
      send_chk(8'hF0, 9'h029, "f0_pending");
      send_chk(8'h29, 9'h000, "break_29");

      send_chk(8'hE0, 9'h000, "e0_pending");
      send_chk(8'h75, 9'h175, "make_e075");
      send_chk(8'hE0, 9'h175, "e0_again");
      send_chk(8'hF0, 9'h175, "e0f0_pending");
      send_chk(8'h75, 9'h000, "break_e075");

      send_chk(8'hE0, 9'h000, "e0_72");
      send_chk(8'h72, 9'h172, "make_e072");
      send_chk(8'h6B, 9'h06B, "make_6b_replaces");
      send_chk(8'hF0, 9'h06B, "f0_72");
      send_chk(8'h72, 9'h06B, "break_72_other");
      send_chk(8'h6B, 9'h06B, "typematic_6b");

      // Partial frame: start + 4 data bits, then idle past the timeout.
      send_bits(8'h5A, 5, 1'b0);
      @(negedge clk);
      check("partial_no_update", bus.crt_data, 9'h06B);
      repeat (TIMEOUT + 100) @(posedge clk);
      @(negedge clk);
      check("timeout_idle", bus.crt_data, 9'h06B);
      send_chk(8'h14, 9'h014, "after_timeout_14");

`ifdef PS2_PARITY_CHECK_EN
      send_bits(8'h74, 11, 1'b1);
      @(negedge clk);
      check("bad_parity_dropped", bus.crt_data, 9'h014);
`else
      send_bits(8'h74, 11, 1'b1);
      @(negedge clk);
      check("bad_parity_accepted", bus.crt_data, 9'h074);
`endif
      send_chk(8'h74, 9'h074, "good_parity_74");

      send_chk(8'hAA, 9'h074, "ignore_aa");
      send_chk(8'hE0, 9'h074, "e0_before_fa");
      send_chk(8'hFA, 9'h074, "ignore_fa");
      send_chk(8'h29, 9'h029, "ext_cleared_by_fa");

      // Lone falling edge with data high is not a start bit.
      ps2_bit(1'b1);
      repeat (HALF) @(posedge clk);
      send_chk(8'hF0, 9'h029, "f0_after_glitch");
      send_chk(8'h29, 9'h000, "break_after_glitch");

      send_chk(8'hE1, 9'h000, "pause_e1");
      send_chk(8'h14, 9'h000, "pause_14");
      send_chk(8'h77, 9'h000, "pause_77");
      send_chk(8'hE1, 9'h000, "pause_e1_b");
      send_chk(8'hF0, 9'h000, "pause_f0");
      send_chk(8'h14, 9'h000, "pause_14_b");
      send_chk(8'hF0, 9'h000, "pause_f0_b");
      send_chk(8'h77, 9'h000, "pause_77_b");
      send_chk(8'h1C, 9'h01C, "after_pause_1c");

      // Reset mid-frame with an E0 pending: flags and frame must be discarded.
      send_chk(8'hE0, 9'h01C, "e0_before_rst");
      send_bits(8'h33, 5, 1'b0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_mid_frame", bus.crt_data, 9'h000);
      rst = 1'b0;
      repeat (HALF) @(posedge clk);
      send_chk(8'h4B, 9'h04B, "after_rst_4b");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
